bound_flasher_ctrl: RTL

//   Parametrised bound-flasher controller with its own lamp counter and step prescaler.

---
 rtl/bound_flasher_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher controller: drives an N-lamp thermometer bar through three
// up/down phases, with kickback to the previous low bound and an optional hold.

// One lamp of the thermometer bar: lit while the count is above its index.
module bf_lamp_cell #(
  parameter int IDX = 0,
  parameter int CW  = 5
) (
  input  logic [CW-1:0] count_i,
  output logic          lamp_o
);
  localparam logic [CW-1:0] C_IDX = CW'(IDX);

  assign lamp_o = (count_i > C_IDX);
endmodule

module bound_flasher_ctrl #(
  parameter int N_LAMPS  = 16,
  parameter int B1       = 5,
  parameter int B2       = 10,
  parameter int STEP_DIV = 1,
  parameter int HOLD_EN  = 0,
  parameter int CW       = $clog2(N_LAMPS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flick,
  output logic [N_LAMPS-1:0] lamps,
  output logic [CW-1:0]      count_o,
  output logic [2:0]         phase,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP1  = 3'd1,
    S_DN1  = 3'd2,
    S_UP2  = 3'd3,
    S_DN2  = 3'd4,
    S_UP3  = 3'd5,
    S_DN3  = 3'd6,
    S_HOLD = 3'd7
  } state_e;

  localparam int            PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_B1     = CW'(B1);
  localparam logic [CW-1:0] C_B2     = CW'(B2);
  localparam logic [CW-1:0] C_N      = CW'(N_LAMPS);
  localparam bit            HOLD_ON  = (HOLD_EN != 0);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pre_q,   pre_d;
  logic          step;

  // Prescaler wraps on the step clock; with STEP_DIV=1 every clock is a step.
  assign step  = (pre_q == PRE_LAST);
  assign pre_d = step ? '0 : pre_q + PRE_ONE;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (flick) begin
          state_d = S_UP1;
          count_d = C_ONE;
        end else begin
          count_d = '0;
        end
      end
      S_UP1: begin
        if (count_q == C_B1) begin
          state_d = S_DN1;
          count_d = C_B1 - C_ONE;
        end else begin
          count_d = count_q + C_ONE;
        end
      end
      S_DN1: begin
        if (count_q == '0) begin
          state_d = S_UP2;
          count_d = C_ONE;
        end else begin
          count_d = count_q - C_ONE;
        end
      end
      S_UP2: begin
        // Kickback wins over the normal turn at B2.
        if (flick && (count_q == C_B1 || count_q == C_B2)) begin
          state_d = S_DN1;
          count_d = count_q - C_ONE;
        end else if (count_q == C_B2) begin
          state_d = S_DN2;
          count_d = C_B2 - C_ONE;
        end else begin
          count_d = count_q + C_ONE;
        end
      end
      S_DN2: begin
        if (HOLD_ON && flick && count_q == C_B1) begin
          state_d = S_HOLD;
        end else if (count_q == C_B1) begin
          state_d = S_UP3;
          count_d = C_B1 + C_ONE;
        end else begin
          count_d = count_q - C_ONE;
        end
      end
      S_UP3: begin
        if (flick && count_q == C_B2) begin
          state_d = S_DN2;
          count_d = count_q - C_ONE;
        end else if (count_q == C_N) begin
          state_d = S_DN3;
          count_d = C_N - C_ONE;
        end else begin
          count_d = count_q + C_ONE;
        end
      end
      S_DN3: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q - C_ONE;
        end
      end
      S_HOLD: begin
        if (!flick) begin
          state_d = S_UP3;
          count_d = C_B1 + C_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
    end else begin
      pre_q <= pre_d;
      if (step) begin
        state_q <= state_d;
        count_q <= count_d;
      end
    end
  end

  // Outputs are plain decodes of the registers: no path from flick.
  assign count_o = count_q;
  assign phase   = state_q;
  assign busy    = (state_q != S_IDLE);

  for (genvar i = 0; i < N_LAMPS; i++) begin : g_lamp
    bf_lamp_cell #(
      .IDX (i),
      .CW  (CW)
    ) u_cell (
      .count_i (count_q),
      .lamp_o  (lamps[i])
    );
  end

endmodule
